// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter sharing one multiplier between two clients.
// Captures operands, registers the product, returns it tagged with the owner ID.
module mul_share_arb #(
    parameter int DATAWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic [DATAWIDTH-1:0]   a0,
    input  logic [DATAWIDTH-1:0]   b0,
    input  logic                   req1,
    input  logic [DATAWIDTH-1:0]   a1,
    input  logic [DATAWIDTH-1:0]   b1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_id,
    output logic [2*DATAWIDTH-1:0] res_prod,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic [DATAWIDTH-1:0]   op_a_q, op_a_d;
    logic [DATAWIDTH-1:0]   op_b_q, op_b_d;
    logic                   gnt0_q, gnt0_d;
    logic                   gnt1_q, gnt1_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_id_q, res_id_d;
    logic [2*DATAWIDTH-1:0] res_prod_q, res_prod_d;

    logic                   any_req;
    logic                   sel1;
    logic [2*DATAWIDTH-1:0] mul_prod;

    // ptr_q=1 gives requester 1 priority; a lone requester always wins
    assign any_req  = req0 | req1;
    assign sel1     = req1 & (~req0 | ptr_q);
    assign mul_prod = {{DATAWIDTH{1'b0}}, op_a_q} * {{DATAWIDTH{1'b0}}, op_b_q};

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: issue on any request, one EXEC cycle, wait in RESP for ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs and datapath: capture winner, load product, release
    always_comb begin
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_prod_d  = res_prod_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    op_a_d   = sel1 ? a1 : a0;
                    op_b_d   = sel1 ? b1 : b0;
                    res_id_d = sel1;
                    gnt0_d   = ~sel1;
                    gnt1_d   = sel1;
                end
            end
            EXEC: begin
                res_prod_d  = mul_prod;
                res_valid_d = 1'b1;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    ptr_d       = ~res_id_q;
                end
            end
            default: begin
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Output and operand flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_prod_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_prod_q  <= res_prod_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_prod  = res_prod_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: scoreboard bench for the shared multiplier arbiter.
// Requester agents hold req until gnt; a monitor checks grants and results.
module tb_mul_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, res_valid, res_id, busy;
    logic        res_ready = 1'b1;
    logic [15:0] res_prod;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_gnt = 0;
    bit have_prev = 0;
    bit ivl_on = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [1:0]  exp_gnt[$];
    logic [16:0] exp_res[$];

    mul_share_arb #(.DATAWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_prod(res_prod),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester agents: present head of queue, retire it on gnt
    initial begin : agent
        forever begin
            @(negedge clk);
            if (gnt0 && q0.size() > 0) void'(q0.pop_front());
            if (gnt1 && q1.size() > 0) void'(q1.pop_front());
            req0 = (q0.size() > 0);
            req1 = (q1.size() > 0);
            if (req0) {a0, b0} = q0[0];
            if (req1) {a1, b1} = q1[0];
        end
    end

    // Monitor: grant order, pulse width, latency, hold under backpressure, results
    initial begin : mon
        logic        pv, pr, pid, pg;
        logic [15:0] pp;
        logic [1:0]  eg;
        logic [16:0] er;
        pv = 0; pr = 0; pid = 0; pg = 0; pp = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst_n) begin
                if (gnt0 || gnt1) begin
                    chk("gnt_both", {31'd0, gnt0 & gnt1}, 0);
                    chk("gnt_pulse", {31'd0, pg}, 0);
                    chk("gnt_in_resp", {31'd0, res_valid}, 0);
                    eg = (exp_gnt.size() > 0) ? exp_gnt.pop_front() : 2'd2;
                    chk("gnt_id", {31'd0, gnt1}, {30'd0, eg});
                    if (ivl_on && have_prev) chk("issue_ivl", cyc - last_gnt, 3);
                    have_prev = 1;
                    last_gnt = cyc;
                end
                if (pv && !pr) begin
                    chk("hold_valid", {31'd0, res_valid}, 1);
                    chk("hold_id", {31'd0, res_id}, {31'd0, pid});
                    chk("hold_prod", {16'd0, res_prod}, {16'd0, pp});
                end
                if (res_valid && !pv) chk("latency", cyc - last_gnt, 1);
                if (res_valid && res_ready) begin
                    er = (exp_res.size() > 0) ? exp_res.pop_front() : 17'h1ffff;
                    chk("res_id", {31'd0, res_id}, {31'd0, er[16]});
                    chk("res_prod", {16'd0, res_prod}, {16'd0, er[15:0]});
                end
                pv = res_valid; pr = res_ready; pid = res_id; pp = res_prod;
                pg = gnt0 | gnt1;
            end else begin
                pv = 0; pg = 0;
            end
        end
    end

    task automatic push_op(input bit id, input logic [7:0] a, input logic [7:0] b);
        if (id) q1.push_back({a, b});
        else    q0.push_back({a, b});
        exp_gnt.push_back({1'b0, id});
        exp_res.push_back({id, 16'(a) * 16'(b)});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_res.size() > 0 || exp_gnt.size() > 0 ||
                q0.size() > 0 || q1.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_res.size() + exp_gnt.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt0"}, {31'd0, gnt0}, 0);
        chk({tag, "_gnt1"}, {31'd0, gnt1}, 0);
        chk({tag, "_valid"}, {31'd0, res_valid}, 0);
        chk({tag, "_id"}, {31'd0, res_id}, 0);
        chk({tag, "_prod"}, {16'd0, res_prod}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        have_prev = 0;
    endtask

    initial begin : stim
        int n;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // single requester 0
        push_op(0, 8'd7, 8'd2);
        drain();

        // simultaneous requests after reset: 0 wins, then 1
        do_reset();
        push_op(0, 8'd25, 8'd5);
        push_op(1, 8'd5, 8'd13);
        drain();

        // both saturated: strict alternation, 3-cycle issue interval
        have_prev = 0;
        ivl_on = 1;
        for (int i = 0; i < 3; i++) begin
            push_op(0, 8'(2 * i + 1), 8'(2 * i + 2));
            push_op(1, 8'(2 * i + 7), 8'(2 * i + 8));
        end
        drain();
        ivl_on = 0;

        // backpressure: result held, no grant to waiting requester 0
        res_ready = 1'b0;
        push_op(1, 8'd39, 8'd1);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", {31'd0, res_valid}, 1);
        push_op(0, 8'd4, 8'd6);
        repeat (5) begin
            @(negedge clk);
            #2;
            chk("bp_no_gnt0", {31'd0, gnt0}, 0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        drain();

        // boundary operands
        push_op(0, 8'd255, 8'd255);
        push_op(0, 8'd0, 8'd200);
        drain();

        // reset during EXEC: discarded, priority back to requester 0
        q0.push_back({8'd9, 8'd9});
        exp_gnt.push_back(2'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt0 && n < 20);
        chk("exec_gnt_seen", {31'd0, gnt0}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        have_prev = 0;
        repeat (4) begin
            @(negedge clk);
            #2;
            chk("no_res_after_rst", {31'd0, res_valid}, 0);
        end
        push_op(1, 8'd3, 8'd3);
        push_op(0, 8'd10, 8'd11);
        exp_gnt.delete();
        exp_res.delete();
        exp_gnt.push_back(2'd0);
        exp_gnt.push_back(2'd1);
        exp_res.push_back({1'b0, 16'd110});
        exp_res.push_back({1'b1, 16'd9});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

endmodule
